// File: rtl/z80_bus_responder.sv
// ---------------------------------------------------------------------------
// z80_bus_responder
//
// Target-side memory and I/O responder for the tv80s bus. The CPU is the
// initiator; this block decodes its strobes, inserts programmable wait
// states, serves reads from internal RAM or a 256-byte I/O file, commits
// each write exactly once, and returns a fixed vector on interrupt
// acknowledge. A backdoor port preloads RAM / I/O while the bus is idle.
//
// Optional feature (compile-time macro Z80_RESP_WRPROT_EN):
//   defined   - CPU memory writes below ROM_TOP complete as normal bus
//               cycles but leave RAM untouched (backdoor is never blocked).
//   undefined - ROM_TOP is ignored; all RAM is writable.
//
// Ports:
//   clk, reset              clock (rising edge), synchronous active-high reset
//   A, cpu_do               CPU address bus and write data
//   mreq_n, iorq_n, rd_n,   CPU bus strobes, active low
//   wr_n, m1_n, rfsh_n
//   di                      read data returned to the CPU
//   wait_n                  wait request to the CPU, active low
//   ld_we, ld_io,           backdoor write strobe, target select (1 = I/O),
//   ld_addr, ld_data        address and data
//   ld_err                  one-cycle pulse when a backdoor write is dropped
//   cyc_cnt                 completed bus cycle count, wraps
// ---------------------------------------------------------------------------
module z80_bus_responder #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 1,
  parameter logic [7:0]  INTA_VEC = 8'hFF,
  parameter logic [15:0] ROM_TOP  = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [7:0]  cpu_do,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic        rfsh_n,
  output logic [7:0]  di,
  output logic        wait_n,
  input  logic        ld_we,
  input  logic        ld_io,
  input  logic [15:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic        ld_err,
  output logic [15:0] cyc_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [3:0] MEM_WAIT_C = 4'(MEM_WAIT);
  localparam logic [3:0] IO_WAIT_C  = 4'(IO_WAIT);

  logic [7:0] ram    [2**ADDR_W];
  logic [7:0] io_mem [256];

  logic [1:0]  state;
  logic [3:0]  cnt;

  // Attributes of the bus cycle in flight, captured at its start.
  logic [15:0] cyc_addr;
  logic        cyc_io;
  logic        cyc_inta;
  logic        cyc_wr;

  logic        start_inta;
  logic        start_io;
  logic        start_mem;
  logic        start;
  logic [3:0]  start_cnt;
  logic        hold_done;
  logic        wr_allow;
  logic        ld_ok;
  logic        cpu_wr;
  logic        ram_we;
  logic        io_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]  io_waddr;
  logic [7:0]  wdata;
  logic [7:0]  rd_data;

  // Cycle decode. INTA outranks I/O (m1_n separates them); refresh is
  // excluded from memory cycles by rfsh_n.
  // NOTE: every always_comb output gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    start_inta = !iorq_n && !m1_n;
    start_io   = !iorq_n && m1_n && (!rd_n || !wr_n);
    start_mem  = !mreq_n && rfsh_n && (!rd_n || !wr_n);
    start      = (state == S_IDLE) && (start_inta || start_io || start_mem);
    start_cnt  = start_inta ? 4'd0 : (start_io ? IO_WAIT_C : MEM_WAIT_C);
    // INTA finishes on its own strobes; other cycles when both requests drop.
    hold_done  = (cyc_inta && rd_n && wr_n && iorq_n) || (mreq_n && iorq_n);
  end

`ifdef Z80_RESP_WRPROT_EN
  always_comb wr_allow = (cyc_addr >= ROM_TOP);
`else
  logic unused_rom_top;
  always_comb begin
    wr_allow       = 1'b1;
    unused_rom_top = ^ROM_TOP;
  end
`endif

  // Single shared write port: the backdoor is only accepted in IDLE and the
  // CPU only writes in ACCESS, so the two sources never collide.
  always_comb begin
    ld_ok     = ld_we && (state == S_IDLE) && !start && !reset;
    cpu_wr    = (state == S_ACCESS) && cyc_wr && !reset;
    ram_we    = (ld_ok && !ld_io) || (cpu_wr && !cyc_io && wr_allow);
    io_we     = (ld_ok && ld_io) || (cpu_wr && cyc_io);
    ram_waddr = ld_ok ? ld_addr[ADDR_W-1:0] : cyc_addr[ADDR_W-1:0];
    io_waddr  = ld_ok ? ld_addr[7:0] : cyc_addr[7:0];
    wdata     = ld_ok ? ld_data : cpu_do;
  end

  always_comb begin
    if (cyc_inta)    rd_data = INTA_VEC;
    else if (cyc_io) rd_data = io_mem[cyc_addr[7:0]];
    else             rd_data = ram[cyc_addr[ADDR_W-1:0]];
  end

  // NOTE: storage has no reset so it maps onto RAM macros and keeps its
  // contents across reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr]   <= wdata;
    if (io_we)  io_mem[io_waddr] <= wdata;
  end

  // Cycle attributes only matter after a start, so they need no reset.
  always_ff @(posedge clk) begin
    if (start) begin
      cyc_addr <= A;
      cyc_io   <= start_io;
      cyc_inta <= start_inta;
      cyc_wr   <= !start_inta && !wr_n;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      wait_n  <= 1'b1;
      di      <= 8'h00;
      ld_err  <= 1'b0;
      cyc_cnt <= 16'h0000;
    end else begin
      ld_err <= ld_we && !ld_ok;
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt <= start_cnt;
            if (start_cnt == 4'd0) begin
              state <= S_ACCESS;
            end else begin
              state  <= S_WAIT;
              wait_n <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          // Releasing wait_n on cnt==1 keeps it low for exactly N cycles.
          if (cnt == 4'd1) begin
            wait_n <= 1'b1;
            state  <= S_ACCESS;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACCESS: begin
          if (!cyc_wr) di <= rd_data;
          cyc_cnt <= cyc_cnt + 16'd1;
          state   <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_z80_bus_responder
//
// Bench for z80_bus_responder. Scripted bus cycles emulate the CPU side; a
// byte-array model of RAM / I/O plus per-cycle expectations for wait_n, di,
// cyc_cnt and ld_err are compared against the DUT on every falling edge.
// Literal checks pin the model at key points (opcode fetches, RRC result,
// I/O round trip, INTA vector, backdoor behaviour, reset mid-cycle).
// Build with +define+Z80_RESP_WRPROT_EN to exercise write protection.
// ---------------------------------------------------------------------------
module tb_z80_bus_responder;

  localparam int unsigned   MEM_WAIT = 3;
  localparam int unsigned   IO_WAIT  = 1;
  localparam logic [7:0]    INTA_VEC = 8'hC7;
  localparam logic [15:0]   ROM_TOP  = 16'h0100;

  typedef enum {K_M1, K_MRD, K_MWR, K_IORD, K_IOWR, K_INTA} kind_e;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] A;
  logic [7:0]  cpu_do;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
  logic [7:0]  di;
  logic        wait_n;
  logic        ld_we, ld_io;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_err;
  logic [15:0] cyc_cnt;

  z80_bus_responder #(
    .ADDR_W  (16),
    .MEM_WAIT(MEM_WAIT),
    .IO_WAIT (IO_WAIT),
    .INTA_VEC(INTA_VEC),
    .ROM_TOP (ROM_TOP)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .cpu_do (cpu_do),
    .mreq_n (mreq_n),
    .iorq_n (iorq_n),
    .rd_n   (rd_n),
    .wr_n   (wr_n),
    .m1_n   (m1_n),
    .rfsh_n (rfsh_n),
    .di     (di),
    .wait_n (wait_n),
    .ld_we  (ld_we),
    .ld_io  (ld_io),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .ld_err (ld_err),
    .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [7:0]  ram_m [65536];
  logic [7:0]  io_m  [256];
  logic [7:0]  exp_di     = 8'h00;
  logic        exp_wait_n = 1'b1;
  logic [15:0] exp_cyc    = 16'h0000;
  logic        exp_ld_err = 1'b0;
  logic        chk_en     = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("wait_n",  16'(wait_n), 16'(exp_wait_n));
      check("di",      16'(di),     16'(exp_di));
      check("cyc_cnt", cyc_cnt,     exp_cyc);
      check("ld_err",  16'(ld_err), 16'(exp_ld_err));
    end
  end

  function automatic logic [7:0] model_read(input kind_e k, input logic [15:0] a);
    if (k == K_INTA) return INTA_VEC;
    if (k == K_IORD) return io_m[a[7:0]];
    return ram_m[a];
  endfunction

  task automatic model_write(input kind_e k, input logic [15:0] a, input logic [7:0] d);
    if (k == K_IOWR) begin
      io_m[a[7:0]] = d;
    end else begin
`ifdef Z80_RESP_WRPROT_EN
      if (a >= ROM_TOP) ram_m[a] = d;
`else
      ram_m[a] = d;
`endif
    end
  endtask

  task automatic release_bus();
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    m1_n = 1'b1; rfsh_n = 1'b1;
  endtask

  // One CPU bus cycle. Called #1 after a rising edge; returns #1 after the
  // edge on which the responder is back in IDLE. extra_hold keeps the
  // strobes asserted (with changed write data) past the access.
  task automatic bus_cycle(input kind_e kind, input logic [15:0] addr,
                           input logic [7:0] wd, input int extra_hold);
    int nw;
    nw = (kind == K_INTA) ? 0 :
         ((kind == K_IORD || kind == K_IOWR) ? int'(IO_WAIT) : int'(MEM_WAIT));
    A = addr;
    cpu_do = wd;
    case (kind)
      K_M1:    begin m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; end
      K_MRD:   begin mreq_n = 1'b0; rd_n = 1'b0; end
      K_MWR:   begin mreq_n = 1'b0; wr_n = 1'b0; end
      K_IORD:  begin iorq_n = 1'b0; rd_n = 1'b0; end
      K_IOWR:  begin iorq_n = 1'b0; wr_n = 1'b0; end
      default: begin m1_n = 1'b0; iorq_n = 1'b0; end
    endcase
    @(posedge clk); #1;
    exp_wait_n = (nw == 0);
    for (int k = 1; k <= nw; k++) begin
      @(posedge clk); #1;
      if (k == nw) exp_wait_n = 1'b1;
    end
    @(posedge clk); #1;
    exp_cyc = exp_cyc + 16'd1;
    if (kind == K_MWR || kind == K_IOWR) model_write(kind, addr, wd);
    else exp_di = model_read(kind, addr);
    if (extra_hold > 0) begin
      cpu_do = ~wd;
      repeat (extra_hold) @(posedge clk);
      #1;
    end
    release_bus();
    @(posedge clk); #1;
  endtask

  task automatic refresh_cycle(input logic [15:0] addr);
    A = addr; mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    release_bus();
    @(posedge clk); #1;
  endtask

  task automatic ld(input logic io, input logic [15:0] a, input logic [7:0] d);
    ld_we = 1'b1; ld_io = io; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_we = 1'b0;
    if (io) io_m[a[7:0]] = d;
    else    ram_m[a] = d;
  endtask

  logic [15:0] ix;
  logic [15:0] ea;
  logic [7:0]  disp;
  logic [7:0]  val;

  initial begin
    reset = 1'b1;
    A = 16'h0000; cpu_do = 8'h00;
    release_bus();
    ld_we = 1'b0; ld_io = 1'b0; ld_addr = 16'h0000; ld_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_di",      16'(di),     16'h0000);
    check("rst_wait_n",  16'(wait_n), 16'h0001);
    check("rst_ld_err",  16'(ld_err), 16'h0000);
    check("rst_cyc_cnt", cyc_cnt,     16'h0000);
    reset = 1'b0;
    @(posedge clk); #1;

    // Preload
    ld(1'b0, 16'h0000, 8'hDD);
    ld(1'b0, 16'h0001, 8'hCB);
    ld(1'b0, 16'h0002, 8'hC6);
    ld(1'b0, 16'h0003, 8'h0E);
    ld(1'b0, 16'hFD0F, 8'hAD);
    ld(1'b0, 16'h1234, 8'h5A);
    ld(1'b0, 16'h3000, 8'h33);
    ld(1'b0, 16'h2000, 8'h11);
    ld(1'b0, 16'h0050, 8'hAB);
    ld(1'b0, 16'h0150, 8'h00);
    ld(1'b1, 16'hABA5, 8'h3C);

    // RRC (IX+C6h) with IX=FD49, bus-level
    ix = 16'hFD49;
    bus_cycle(K_M1, 16'h0000, 8'h00, 0);
    check("fetch_dd", 16'(di), 16'h00DD);
    refresh_cycle(16'h0000);
    bus_cycle(K_M1, 16'h0001, 8'h00, 0);
    check("fetch_cb", 16'(di), 16'h00CB);
    refresh_cycle(16'h0001);
    bus_cycle(K_MRD, 16'h0002, 8'h00, 0);
    disp = di;
    bus_cycle(K_MRD, 16'h0003, 8'h00, 0);
    check("fetch_op", 16'(di), 16'h000E);
    ea = ix + {{8{disp[7]}}, disp};
    check("ix_disp_ea", ea, 16'hFD0F);
    bus_cycle(K_MRD, ea, 8'h00, 0);
    val = di;
    bus_cycle(K_MWR, ea, {val[0], val[7:1]}, 3);
    bus_cycle(K_MRD, 16'hFD0F, 8'h00, 0);
    check("rrc_result", 16'(di), 16'h00D6);

    // Wait-state read
    bus_cycle(K_MRD, 16'h1234, 8'h00, 0);
    check("mrd_1234", 16'(di), 16'h005A);
    check("cyc_after_8", cyc_cnt, 16'd8);

    // OUT (7F),A then IN A,(7F) with different high byte
    bus_cycle(K_IOWR, 16'h427F, 8'h42, 0);
    bus_cycle(K_IORD, 16'h997F, 8'h00, 0);
    check("io_7f", 16'(di), 16'h0042);
    bus_cycle(K_IORD, 16'h12A5, 8'h00, 0);
    check("io_a5_backdoor", 16'(di), 16'h003C);

    // Interrupt acknowledge
    bus_cycle(K_INTA, 16'h1234, 8'h00, 0);
    check("inta_vec", 16'(di), 16'h00C7);

    // Backdoor rejected during WAIT
    fork
      bus_cycle(K_MRD, 16'h1234, 8'h00, 0);
      begin
        repeat (2) @(posedge clk);
        #1;
        ld_we = 1'b1; ld_io = 1'b0; ld_addr = 16'h3000; ld_data = 8'hEE;
        @(posedge clk); #1;
        ld_we = 1'b0; exp_ld_err = 1'b1;
        check("ld_err_in_wait", 16'(ld_err), 16'h0001);
        @(posedge clk); #1;
        exp_ld_err = 1'b0;
      end
    join
    bus_cycle(K_MRD, 16'h3000, 8'h00, 0);
    check("ld_drop_wait", 16'(di), 16'h0033);

    // Backdoor rejected when a start lands on the same edge
    fork
      bus_cycle(K_MRD, 16'h1234, 8'h00, 0);
      begin
        ld_we = 1'b1; ld_io = 1'b0; ld_addr = 16'h3000; ld_data = 8'h99;
        @(posedge clk); #1;
        ld_we = 1'b0; exp_ld_err = 1'b1;
        @(posedge clk); #1;
        exp_ld_err = 1'b0;
      end
    join
    bus_cycle(K_MRD, 16'h3000, 8'h00, 0);
    check("ld_drop_start", 16'(di), 16'h0033);

    // Backdoor accepted in IDLE
    ld(1'b0, 16'h3000, 8'hEE);
    bus_cycle(K_MRD, 16'h3000, 8'h00, 0);
    check("ld_idle", 16'(di), 16'h00EE);

    // Writes around ROM_TOP
    bus_cycle(K_MWR, 16'h0050, 8'h77, 0);
    bus_cycle(K_MWR, 16'h0150, 8'h77, 0);
    bus_cycle(K_MRD, 16'h0050, 8'h00, 0);
`ifdef Z80_RESP_WRPROT_EN
    check("wrprot_0050", 16'(di), 16'h00AB);
`else
    check("wr_0050", 16'(di), 16'h0077);
`endif
    bus_cycle(K_MRD, 16'h0150, 8'h00, 0);
    check("wr_0150", 16'(di), 16'h0077);

    // Reset during a waited write
    A = 16'h2000; cpu_do = 8'h55; mreq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk); #1;
    exp_wait_n = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    exp_wait_n = 1'b1; exp_di = 8'h00; exp_cyc = 16'h0000;
    check("rst_mid_wait_n", 16'(wait_n), 16'h0001);
    check("rst_mid_cyc",    cyc_cnt,     16'h0000);
    release_bus();
    reset = 1'b0;
    @(posedge clk); #1;
    bus_cycle(K_MRD, 16'h2000, 8'h00, 0);
    check("rst_write_dropped", 16'(di), 16'h0011);
    check("cyc_after_rst", cyc_cnt, 16'd1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
